// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared constants and types for the doubleword data-memory arbiter
package dmem_pkg;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 64;
    localparam int NBYTES = DATA_W / 8;

    typedef enum logic [1:0] {IDLE, XFER, DRAIN, DONE} state_t;

    typedef enum logic {PORT_C, PORT_L} port_t;

endpackage

// File: rtl/dmem_if.sv
// rtl/dmem_if.sv - requester ports, byte-memory port and status of the data-memory arbiter
interface dmem_if;
    import dmem_pkg::*;

    logic              c_req;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;
    logic              c_ready;
    logic [DATA_W-1:0] c_rdata;

    logic              l_req;
    logic              l_we;
    logic [ADDR_W-1:0] l_addr;
    logic [DATA_W-1:0] l_wdata;
    logic              l_ready;
    logic [DATA_W-1:0] l_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    logic              busy;
    logic              err;

    modport slave (
        input  c_req, c_we, c_addr, c_wdata,
        input  l_req, l_we, l_addr, l_wdata,
        input  mem_rdata,
        output c_ready, c_rdata, l_ready, l_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        output busy, err
    );

    modport master (
        output c_req, c_we, c_addr, c_wdata,
        output l_req, l_we, l_addr, l_wdata,
        output mem_rdata,
        input  c_ready, c_rdata, l_ready, l_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        input  busy, err
    );

endinterface

// File: rtl/dmem_rr_arb.sv
// rtl/dmem_rr_arb.sv - two-way round-robin grant between the CPU and loader ports
module dmem_rr_arb
    import dmem_pkg::*;
(
    input  logic  c_req_i,
    input  logic  l_req_i,
    input  port_t last_grant_i,
    output logic  gnt_valid_o,
    output port_t gnt_id_o
);

    assign gnt_valid_o = c_req_i | l_req_i;

    always_comb begin
        gnt_id_o = PORT_C;
        if (c_req_i && l_req_i) begin
            gnt_id_o = (last_grant_i == PORT_C) ? PORT_L : PORT_C;
        end else if (l_req_i) begin
            gnt_id_o = PORT_L;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - shares a byte-wide data memory between two doubleword requesters
// DMEM_ALIGN_CHECK_EN: reject addresses not doubleword aligned with an err pulse instead of accessing memory.
module dmem_arbiter
    import dmem_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    dmem_if.slave bus
);

    state_t            state_q;
    port_t             port_q;
    port_t             last_grant_q;
    logic              we_q;
    logic [2:0]        cnt_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] shadow_q;
    logic [DATA_W-1:0] c_rdata_q;
    logic [DATA_W-1:0] l_rdata_q;
    logic              c_ready_q;
    logic              l_ready_q;
    logic              mem_en_q;
    logic              mem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [7:0]        mem_wdata_q;
    logic              err_q;
    logic              err_pend_q;

    logic              gnt_valid;
    port_t             gnt_id;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              misaligned;

    dmem_rr_arb u_arb (
        .c_req_i      (bus.c_req),
        .l_req_i      (bus.l_req),
        .last_grant_i (last_grant_q),
        .gnt_valid_o  (gnt_valid),
        .gnt_id_o     (gnt_id)
    );

    always_comb begin
        sel_we    = bus.c_we;
        sel_addr  = bus.c_addr;
        sel_wdata = bus.c_wdata;
        if (gnt_id == PORT_L) begin
            sel_we    = bus.l_we;
            sel_addr  = bus.l_addr;
            sel_wdata = bus.l_wdata;
        end
    end

`ifdef DMEM_ALIGN_CHECK_EN
    assign misaligned = (sel_addr[2:0] != 3'd0);
`else
    assign misaligned = 1'b0;
`endif

    // Store data leaves through a right-shifting register; load bytes enter the shadow from the top.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            port_q       <= PORT_C;
            last_grant_q <= PORT_L;
            we_q         <= 1'b0;
            cnt_q        <= '0;
            wdata_q      <= '0;
            shadow_q     <= '0;
            c_rdata_q    <= '0;
            l_rdata_q    <= '0;
            c_ready_q    <= 1'b0;
            l_ready_q    <= 1'b0;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            err_q        <= 1'b0;
            err_pend_q   <= 1'b0;
        end else begin
            c_ready_q <= 1'b0;
            l_ready_q <= 1'b0;
            err_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (gnt_valid) begin
                        port_q       <= gnt_id;
                        last_grant_q <= gnt_id;
                        we_q         <= sel_we;
                        cnt_q        <= '0;
                        err_pend_q   <= misaligned;
                        if (misaligned) begin
                            state_q <= DONE;
                        end else begin
                            state_q     <= XFER;
                            mem_en_q    <= 1'b1;
                            mem_we_q    <= sel_we;
                            mem_addr_q  <= sel_addr;
                            mem_wdata_q <= sel_wdata[7:0];
                            wdata_q     <= sel_wdata >> 8;
                        end
                    end
                end
                XFER: begin
                    if (!we_q && cnt_q != 3'd0) begin
                        shadow_q <= {bus.mem_rdata, shadow_q[DATA_W-1:8]};
                    end
                    if (cnt_q == 3'(NBYTES - 1)) begin
                        mem_en_q <= 1'b0;
                        mem_we_q <= 1'b0;
                        state_q  <= we_q ? DONE : DRAIN;
                    end else begin
                        cnt_q       <= cnt_q + 3'd1;
                        mem_addr_q  <= mem_addr_q + ADDR_W'(1);
                        mem_wdata_q <= wdata_q[7:0];
                        wdata_q     <= wdata_q >> 8;
                    end
                end
                DRAIN: begin
                    shadow_q <= {bus.mem_rdata, shadow_q[DATA_W-1:8]};
                    state_q  <= DONE;
                end
                DONE: begin
                    state_q <= IDLE;
                    err_q   <= err_pend_q;
                    if (port_q == PORT_C) begin
                        c_ready_q <= 1'b1;
                        if (!we_q && !err_pend_q) c_rdata_q <= shadow_q;
                    end else begin
                        l_ready_q <= 1'b1;
                        if (!we_q && !err_pend_q) l_rdata_q <= shadow_q;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.c_ready   = c_ready_q;
    assign bus.l_ready   = l_ready_q;
    assign bus.c_rdata   = c_rdata_q;
    assign bus.l_rdata   = l_rdata_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = (state_q != IDLE);
    assign bus.err       = err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - randomized and directed bench for dmem_arbiter against a timing-rule model
module tb_dmem_arbiter;
    import dmem_pkg::*;

`ifdef DMEM_ALIGN_CHECK_EN
    localparam bit ALIGN = 1'b1;
`else
    localparam bit ALIGN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dmem_if bus();

    dmem_arbiter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int ntot = 0;
    int nbad = 0;
    int cyc = 0;
    int en_cnt = 0;

    logic [7:0] mem [8192];
    logic [7:0] ref_mem [8192];

    // Expected outputs per cycle, indexed by cycle number modulo 64.
    bit                r_en [64];
    bit                r_we [64];
    bit                r_busy [64];
    bit                r_crdy [64];
    bit                r_lrdy [64];
    bit                r_err [64];
    bit                r_cupd [64];
    bit                r_lupd [64];
    logic [ADDR_W-1:0] r_addr [64];
    logic [7:0]        r_wd [64];
    logic [DATA_W-1:0] r_rd [64];
    logic [DATA_W-1:0] exp_c_rd = '0;
    logic [DATA_W-1:0] exp_l_rd = '0;

    function automatic logic [7:0] init_byte(int i);
        return 8'((i * 37) ^ (i >> 5));
    endfunction

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp);
        ntot++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s cyc=%0d act=%h exp=%h", nm, cyc, act, exp);
        end
    endfunction

    function automatic void clr(int k);
        r_en[k] = 0; r_we[k] = 0; r_busy[k] = 0; r_crdy[k] = 0; r_lrdy[k] = 0;
        r_err[k] = 0; r_cupd[k] = 0; r_lupd[k] = 0;
        r_addr[k] = '0; r_wd[k] = '0; r_rd[k] = '0;
    endfunction

    initial begin
        bus.mem_rdata <= 8'h00;
        for (int i = 0; i < 8192; i++) mem[i] = init_byte(i);
        forever begin
            @(posedge clk);
            if (bus.mem_en === 1'b1) begin
                if (bus.mem_we) mem[bus.mem_addr] = bus.mem_wdata;
                else bus.mem_rdata <= mem[bus.mem_addr];
            end
        end
    end

    // Model: a grant at edge E yields strobes in cycles E..E+7, then ready after 10 (store) or 11 (load) cycles.
    initial begin
        bit p, we, m_last;
        logic [ADDR_W-1:0] a, ak;
        logic [DATA_W-1:0] d, rd;
        int m_free;
        m_free = 0;
        m_last = 1'b1;
        for (int i = 0; i < 8192; i++) ref_mem[i] = init_byte(i);
        for (int k = 0; k < 64; k++) clr(k);
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) begin
                for (int k = 0; k < 64; k++) clr(k);
                r_cupd[cyc & 63] = 1; r_lupd[cyc & 63] = 1; r_rd[cyc & 63] = '0;
                m_free = cyc + 1;
                m_last = 1'b1;
            end else if (cyc >= m_free && (bus.c_req || bus.l_req)) begin
                p = (bus.c_req && bus.l_req) ? !m_last : bus.l_req;
                m_last = p;
                we = p ? bus.l_we : bus.c_we;
                a  = p ? bus.l_addr : bus.c_addr;
                d  = p ? bus.l_wdata : bus.c_wdata;
                if (ALIGN && a[2:0] != 3'd0) begin
                    r_busy[cyc & 63] = 1;
                    if (p) r_lrdy[(cyc + 1) & 63] = 1; else r_crdy[(cyc + 1) & 63] = 1;
                    r_err[(cyc + 1) & 63] = 1;
                    m_free = cyc + 2;
                end else begin
                    rd = '0;
                    for (int k = 0; k < 8; k++) begin
                        ak = a + 13'(k);
                        r_en[(cyc + k) & 63] = 1;
                        r_we[(cyc + k) & 63] = we;
                        r_addr[(cyc + k) & 63] = ak;
                        r_wd[(cyc + k) & 63] = d[8*k +: 8];
                        r_busy[(cyc + k) & 63] = 1;
                        if (we) ref_mem[ak] = d[8*k +: 8];
                        else rd[8*k +: 8] = ref_mem[ak];
                    end
                    r_busy[(cyc + 8) & 63] = 1;
                    if (we) begin
                        if (p) r_lrdy[(cyc + 9) & 63] = 1; else r_crdy[(cyc + 9) & 63] = 1;
                        m_free = cyc + 10;
                    end else begin
                        r_busy[(cyc + 9) & 63] = 1;
                        if (p) begin
                            r_lrdy[(cyc + 10) & 63] = 1; r_lupd[(cyc + 10) & 63] = 1;
                        end else begin
                            r_crdy[(cyc + 10) & 63] = 1; r_cupd[(cyc + 10) & 63] = 1;
                        end
                        r_rd[(cyc + 10) & 63] = rd;
                        m_free = cyc + 11;
                    end
                end
            end
        end
    end

    initial begin
        int s;
        forever begin
            @(negedge clk);
            if (cyc > 0) begin
                s = cyc & 63;
                if (r_cupd[s]) exp_c_rd = r_rd[s];
                if (r_lupd[s]) exp_l_rd = r_rd[s];
                chk("mem_en", bus.mem_en, r_en[s]);
                if (r_en[s] && bus.mem_en) begin
                    chk("mem_we", bus.mem_we, r_we[s]);
                    chk("mem_addr", bus.mem_addr, r_addr[s]);
                    if (r_we[s]) chk("mem_wdata", bus.mem_wdata, r_wd[s]);
                end
                chk("busy", bus.busy, r_busy[s]);
                chk("c_ready", bus.c_ready, r_crdy[s]);
                chk("l_ready", bus.l_ready, r_lrdy[s]);
                chk("err", bus.err, r_err[s]);
                chk("c_rdata", bus.c_rdata, exp_c_rd);
                chk("l_rdata", bus.l_rdata, exp_l_rd);
                clr(s);
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (bus.mem_en === 1'b1) en_cnt++;
        end
    end

    // Must be called at a falling edge; lat counts cycles from the first sampling edge to ready.
    task automatic xfer(input bit p, input bit we, input logic [12:0] a,
                        input logic [63:0] d, output int lat);
        int n;
        n = 0;
        if (p) begin
            bus.l_we = we; bus.l_addr = a; bus.l_wdata = d; bus.l_req = 1'b1;
        end else begin
            bus.c_we = we; bus.c_addr = a; bus.c_wdata = d; bus.c_req = 1'b1;
        end
        do begin
            @(negedge clk);
            n++;
        end while (((p ? bus.l_ready : bus.c_ready) !== 1'b1) && n < 300);
        chk(p ? "l_xfer_ready" : "c_xfer_ready", p ? bus.l_ready : bus.c_ready, 1);
        if (p) bus.l_req = 1'b0; else bus.c_req = 1'b0;
        lat = n;
    endtask

    task automatic rand_port(input bit p, input int n);
        int lat;
        logic [12:0] a;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            a = ($urandom_range(0, 1) == 1) ? 13'($urandom_range(0, 40))
                                            : 13'(8192 - $urandom_range(1, 12));
            xfer(p, 1'($urandom_range(0, 1)), a, {$urandom, $urandom}, lat);
        end
    endtask

    initial begin
        int lc, ll, e0, seen;
        reset = 1'b1;
        bus.c_req = 0; bus.c_we = 0; bus.c_addr = '0; bus.c_wdata = '0;
        bus.l_req = 0; bus.l_we = 0; bus.l_addr = '0; bus.l_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 0);
        chk("rst_mem_en", bus.mem_en, 0);
        chk("rst_mem_we", bus.mem_we, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);
        chk("rst_readys", {bus.c_ready, bus.l_ready, bus.err}, 0);
        chk("rst_c_rdata", bus.c_rdata, 0);
        chk("rst_l_rdata", bus.l_rdata, 0);
        reset = 1'b0;

        fork
            xfer(1'b0, 1'b1, 13'd16, 64'h0807060504030201, lc);
            xfer(1'b1, 1'b1, 13'd96, 64'h1122334455667788, ll);
        join
        chk("cont1_c_lat", lc, 10);
        chk("cont1_l_lat", ll, 20);
        for (int k = 0; k < 8; k++) chk("store_byte", mem[16 + k], 8'(k + 1));

        e0 = en_cnt;
        xfer(1'b0, 1'b0, 13'd16, '0, lc);
        chk("load_lat", lc, 11);
        chk("load_data", bus.c_rdata, 64'h0807060504030201);
        chk("load_en_cycles", en_cnt - e0, 8);

`ifdef DMEM_ALIGN_CHECK_EN
        e0 = en_cnt;
        xfer(1'b0, 1'b0, 13'd3, '0, lc);
        chk("align_lat", lc, 2);
        chk("align_err", bus.err, 1);
        chk("align_rdata", bus.c_rdata, 64'h0807060504030201);
        chk("align_no_en", en_cnt - e0, 0);
`endif

        fork
            xfer(1'b0, 1'b0, 13'd96, '0, lc);
            xfer(1'b1, 1'b0, 13'd16, '0, ll);
        join
        chk("cont2_l_lat", ll, 11);
        chk("cont2_c_lat", lc, 22);
        chk("cont2_l_data", bus.l_rdata, 64'h0807060504030201);
        chk("cont2_c_data", bus.c_rdata, 64'h1122334455667788);

`ifndef DMEM_ALIGN_CHECK_EN
        xfer(1'b1, 1'b1, 13'd8190, 64'hFFEEDDCCBBAA9988, ll);
        chk("wrap_lat", ll, 10);
        chk("wrap_8190", mem[8190], 8'h88);
        chk("wrap_8191", mem[8191], 8'h99);
        chk("wrap_0", mem[0], 8'hAA);
        chk("wrap_5", mem[5], 8'hFF);
`endif

        fork
            rand_port(1'b0, 30);
            rand_port(1'b1, 30);
        join

        xfer(1'b0, 1'b1, 13'd40, 64'h1111111111111111, lc);
        bus.c_we = 1'b1; bus.c_addr = 13'd40; bus.c_wdata = 64'h2222222222222222; bus.c_req = 1'b1;
        repeat (4) @(negedge clk);
        chk("abort_en", bus.mem_en, 1);
        chk("abort_addr", bus.mem_addr, 13'd43);
        reset = 1'b1;
        bus.c_req = 1'b0;
        @(negedge clk);
        chk("abort_busy", bus.busy, 0);
        chk("abort_mem_en", bus.mem_en, 0);
        chk("abort_c_ready", bus.c_ready, 0);
        reset = 1'b0;
        seen = 0;
        repeat (15) begin
            @(negedge clk);
            if (bus.c_ready === 1'b1 || bus.mem_en === 1'b1) seen++;
        end
        chk("abort_quiet", seen, 0);
        for (int k = 0; k < 4; k++) chk("abort_written", mem[40 + k], 8'h22);
        for (int k = 4; k < 8; k++) chk("abort_untouched", mem[40 + k], 8'h11);

        $display("test done: total=%0d bad=%0d", ntot, nbad);
        $finish;
    end

endmodule
